// File: rtl/pipelined_array_mult.sv
// Pipelined M x N array multiplier with valid/ready flow control.
// Each stage accumulates ROWS_PER_STAGE partial-product rows; unsigned or Baugh-Wooley signed.
module pipelined_array_mult #(
  parameter int unsigned M              = 4,
  parameter int unsigned N              = 4,
  parameter int unsigned ROWS_PER_STAGE = 2,
  parameter int unsigned TAG_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M+N-1:0]     out_product,
  output logic               out_signed,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned P = M + N;
  localparam int unsigned S = (N + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  // Baugh-Wooley correction: 2^(M-1) + 2^(N-1) + 2^(M+N-1), modulo 2^(M+N).
  localparam logic [P-1:0] BwCorr =
      P'((64'd1 << (M - 1)) + (64'd1 << (N - 1)) + (64'd1 << (P - 1)));

  logic [S-1:0]     vld_q, vld_d;
  logic [S-1:0]     adv, load;
  logic [P-1:0]     acc_q [S];
  logic [P-1:0]     acc_d [S];
  logic [M-1:0]     a_q   [S];
  logic [M-1:0]     a_d   [S];
  logic [N-1:0]     b_q   [S];
  logic [N-1:0]     b_d   [S];
  logic [S-1:0]     sgn_q, sgn_d;
  logic [TAG_W-1:0] tag_q [S];
  logic [TAG_W-1:0] tag_d [S];

  // One partial-product row, shifted into place; in signed mode the MSB row and
  // MSB column are inverted, except their shared corner bit.
  function automatic logic [P-1:0] pp_row(input logic [M-1:0] a, input logic b_bit,
                                           input int r, input logic sgn);
    logic [P-1:0] row;
    logic         inv;
    row = '0;
    for (int j = 0; j < int'(M); j++) begin
      inv        = sgn & ((r == int'(N) - 1) ^ (j == int'(M) - 1));
      row[r + j] = (a[j] & b_bit) ^ inv;
    end
    return row;
  endfunction

  // Advance chain walks from the output back to stage 0.
  always_comb begin
    logic free;
    free = out_ready;
    adv  = '0;
    for (int k = int'(S) - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] & free;
      free   = ~vld_q[k] | adv[k];
    end
    in_ready = free;
  end

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < int'(S); k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < int'(S); k++) begin
      vld_d[k] = load[k] | (vld_q[k] & ~adv[k]);
    end
  end

  always_comb begin
    logic [P-1:0]     acc;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             sg;
    logic [TAG_W-1:0] tg;
    for (int k = 0; k < int'(S); k++) begin
      if (k == 0) begin
        acc = in_signed ? BwCorr : '0;
        a   = in_a;
        b   = in_b;
        sg  = in_signed;
        tg  = in_tag;
      end else begin
        acc = acc_q[k-1];
        a   = a_q[k-1];
        b   = b_q[k-1];
        sg  = sgn_q[k-1];
        tg  = tag_q[k-1];
      end
      for (int r = 0; r < int'(N); r++) begin
        if (r >= k * int'(ROWS_PER_STAGE) && r < (k + 1) * int'(ROWS_PER_STAGE)) begin
          acc = acc + pp_row(a, b[r], r, sg);
        end
      end
      acc_d[k] = acc;
      a_d[k]   = a;
      b_d[k]   = b;
      sgn_d[k] = sg;
      tag_d[k] = tg;
    end
  end

  // Data registers load only on a capture so idle or stalled stages do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sgn_q <= '0;
      for (int k = 0; k < int'(S); k++) begin
        acc_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < int'(S); k++) begin
        if (load[k]) begin
          acc_q[k] <= acc_d[k];
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sgn_q[k] <= sgn_d[k];
          tag_q[k] <= tag_d[k];
        end
      end
    end
  end

  assign out_valid   = vld_q[S-1];
  assign out_product = acc_q[S-1];
  assign out_signed  = sgn_q[S-1];
  assign out_tag     = tag_q[S-1];

endmodule
